// File: rtl/pong_game_ctrl_if.sv
// Pong game-flow controller signal bundle.
// The graph unit and buttons drive it; the text/rgb mux reads game status from it.
interface pong_game_ctrl_if #(
    parameter int BALL_W = 4,
    parameter int DIGITS = 2
);
    logic                  frame_tick;
    logic [1:0]            btn;
    logic                  pause_btn;
    logic                  hit;
    logic                  miss;
    logic                  gra_still;
    logic [2:0]            state;
    logic [BALL_W-1:0]     balls;
    logic [4*DIGITS-1:0]   score;
    logic [4*DIGITS-1:0]   hi_score;
    logic                  new_hi;

    modport slave (
        input  frame_tick, btn, pause_btn, hit, miss,
        output gra_still, state, balls, score, hi_score, new_hi
    );

    modport master (
        output frame_tick, btn, pause_btn, hit, miss,
        input  gra_still, state, balls, score, hi_score, new_hi
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSMD: state, balls left, saturating BCD score,
// frame wait timer, pause toggle and high-score tracking.
module pong_game_ctrl #(
    parameter int BALLS       = 3,
    parameter int BALL_W      = 4,
    parameter int DIGITS      = 2,
    parameter int WAIT_FRAMES = 120,
    parameter int OVER_FRAMES = 120,
    parameter int TIMER_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    pong_game_ctrl_if.slave       g
);

    typedef enum logic [2:0] {
        S_NEWGAME = 3'd0,
        S_PLAY    = 3'd1,
        S_NEWBALL = 3'd2,
        S_OVER    = 3'd3,
        S_PAUSE   = 3'd4
    } state_t;

    localparam int SW = 4 * DIGITS;

    localparam logic [BALL_W-1:0]  BALLS_V = BALL_W'(BALLS);
    localparam logic [BALL_W-1:0]  BALLS_M1 = BALL_W'(BALLS - 1);
    localparam logic [TIMER_W-1:0] WAIT_V = TIMER_W'(WAIT_FRAMES);
    localparam logic [TIMER_W-1:0] OVER_V = TIMER_W'(OVER_FRAMES);
    localparam logic [SW-1:0]      ALL9 = {DIGITS{4'h9}};

    state_t              state_q, state_d;
    logic [BALL_W-1:0]   balls_q, balls_d;
    logic [SW-1:0]       score_q, score_d;
    logic [SW-1:0]       hi_q, hi_d;
    logic                new_hi_q, new_hi_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                pause_q, pause_d;

    logic                pause_edge;
    logic                btn_any;
    logic                timer_zero;
    logic [SW-1:0]       score_inc;
    logic                score_gt_hi;

    // Ripple-carry BCD increment that sticks at all-9s instead of wrapping.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        if (v != ALL9) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (c) begin
                    if (v[4*i +: 4] >= 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Digit-wise compare, most-significant digit decides first.
    function automatic logic bcd_gt(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b
    );
        logic gt;
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!done) begin
                if (a[4*i +: 4] > b[4*i +: 4]) begin
                    gt   = 1'b1;
                    done = 1'b1;
                end else if (a[4*i +: 4] < b[4*i +: 4]) begin
                    done = 1'b1;
                end
            end
        end
        return gt;
    endfunction

    assign pause_edge  = g.pause_btn & ~pause_q;
    assign btn_any     = |g.btn;
    assign timer_zero  = (timer_q == '0);
    assign score_inc   = bcd_inc(score_q);
    assign score_gt_hi = bcd_gt(score_q, hi_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_NEWGAME;
            balls_q  <= BALLS_V;
            score_q  <= '0;
            hi_q     <= '0;
            new_hi_q <= 1'b0;
            timer_q  <= '0;
            pause_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            balls_q  <= balls_d;
            score_q  <= score_d;
            hi_q     <= hi_d;
            new_hi_q <= new_hi_d;
            timer_q  <= timer_d;
            pause_q  <= pause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        balls_d  = balls_q;
        score_d  = score_q;
        hi_d     = hi_q;
        new_hi_d = new_hi_q;
        pause_d  = g.pause_btn;
        timer_d  = timer_q;

        if (g.frame_tick && !timer_zero) begin
            timer_d = timer_q - 1'b1;
        end

        unique case (state_q)
            S_NEWGAME: begin
                score_d = '0;
                balls_d = BALLS_V;
                if (btn_any) begin
                    state_d  = S_PLAY;
                    balls_d  = BALLS_M1;
                    new_hi_d = 1'b0;
                end
            end
            S_PLAY: begin
                if (g.hit) begin
                    score_d = score_inc;
                end
                // A lost ball outranks a pause request in the same cycle.
                if (g.miss) begin
                    if (balls_q == '0) begin
                        state_d = S_OVER;
                        timer_d = OVER_V;
                    end else begin
                        state_d = S_NEWBALL;
                        balls_d = balls_q - 1'b1;
                        timer_d = WAIT_V;
                    end
                end else if (pause_edge) begin
                    state_d = S_PAUSE;
                end
            end
            S_NEWBALL: begin
                if (timer_zero && btn_any) begin
                    state_d = S_PLAY;
                end
            end
            S_OVER: begin
                if (score_gt_hi) begin
                    hi_d     = score_q;
                    new_hi_d = 1'b1;
                end
                if (timer_zero) begin
                    state_d = S_NEWGAME;
                end
            end
            S_PAUSE: begin
                if (pause_edge) begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                state_d = S_NEWGAME;
            end
        endcase
    end

    assign g.gra_still = (state_q != S_PLAY);
    assign g.state     = state_q;
    assign g.balls     = balls_q;
    assign g.score     = score_q;
    assign g.hi_score  = hi_q;
    assign g.new_hi    = new_hi_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with hand-computed expectations.
module tb_pong_game_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    pong_game_ctrl_if #(.BALL_W(4), .DIGITS(2)) g ();

    pong_game_ctrl #(
        .BALLS(3), .BALL_W(4), .DIGITS(2),
        .WAIT_FRAMES(120), .OVER_FRAMES(120), .TIMER_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .g     (g.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(g.state), 32'd0);
        check({tag, "_balls"}, 32'(g.balls), 32'd3);
        check({tag, "_score"}, 32'(g.score), 32'h00);
        check({tag, "_hi"}, 32'(g.hi_score), 32'h00);
        check({tag, "_newhi"}, 32'(g.new_hi), 32'd0);
        check({tag, "_still"}, 32'(g.gra_still), 32'd1);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        g.frame_tick = 1'b0;
        g.btn = 2'b00;
        g.pause_btn = 1'b0;
        g.hit = 1'b0;
        g.miss = 1'b0;
        cycles(2);
        check_reset_vals("rst");
        reset = 1'b0;
        step();

        // start game
        g.btn = 2'b01;
        step();
        g.btn = 2'b00;
        check("start_state", 32'(g.state), 32'd1);
        check("start_balls", 32'(g.balls), 32'd2);
        check("start_still", 32'(g.gra_still), 32'd0);

        g.hit = 1'b1;
        cycles(4);
        g.hit = 1'b0;
        check("hit4_score", 32'(g.score), 32'h04);

        // first miss, button held through countdown
        g.miss = 1'b1;
        step();
        g.miss = 1'b0;
        check("miss1_state", 32'(g.state), 32'd2);
        check("miss1_balls", 32'(g.balls), 32'd1);
        g.frame_tick = 1'b1;
        g.btn = 2'b01;
        cycles(120);
        check("nb_hold_state", 32'(g.state), 32'd2);
        step();
        check("nb_exit_state", 32'(g.state), 32'd1);
        g.frame_tick = 1'b0;
        g.btn = 2'b00;

        // second miss, press after countdown
        g.miss = 1'b1;
        step();
        g.miss = 1'b0;
        check("miss2_state", 32'(g.state), 32'd2);
        check("miss2_balls", 32'(g.balls), 32'd0);
        g.frame_tick = 1'b1;
        cycles(120);
        g.frame_tick = 1'b0;
        g.btn = 2'b10;
        step();
        g.btn = 2'b00;
        check("serve3_state", 32'(g.state), 32'd1);

        // hit and miss together on last ball
        g.hit = 1'b1;
        g.miss = 1'b1;
        step();
        g.hit = 1'b0;
        g.miss = 1'b0;
        check("hm_state", 32'(g.state), 32'd3);
        check("hm_score", 32'(g.score), 32'h05);
        check("hm_balls", 32'(g.balls), 32'd0);
        check("hm_hi_pre", 32'(g.hi_score), 32'h00);
        step();
        check("over_hi", 32'(g.hi_score), 32'h05);
        check("over_newhi", 32'(g.new_hi), 32'd1);
        g.frame_tick = 1'b1;
        cycles(120);
        check("over_hold", 32'(g.state), 32'd3);
        step();
        check("over_exit", 32'(g.state), 32'd0);
        g.frame_tick = 1'b0;
        step();
        check("ng_score", 32'(g.score), 32'h00);
        check("ng_balls", 32'(g.balls), 32'd3);
        check("ng_newhi", 32'(g.new_hi), 32'd1);
        check("ng_hi", 32'(g.hi_score), 32'h05);

        // second game: pause
        g.btn = 2'b10;
        step();
        g.btn = 2'b00;
        check("g2_state", 32'(g.state), 32'd1);
        check("g2_newhi", 32'(g.new_hi), 32'd0);
        g.pause_btn = 1'b1;
        step();
        check("pause_state", 32'(g.state), 32'd4);
        check("pause_still", 32'(g.gra_still), 32'd1);
        g.hit = 1'b1;
        g.miss = 1'b1;
        step();
        g.hit = 1'b0;
        g.miss = 1'b0;
        step();
        check("pause_held", 32'(g.state), 32'd4);
        check("pause_score", 32'(g.score), 32'h00);
        check("pause_balls", 32'(g.balls), 32'd2);
        g.pause_btn = 1'b0;
        step();
        g.pause_btn = 1'b1;
        step();
        check("resume_state", 32'(g.state), 32'd1);
        g.pause_btn = 1'b0;
        step();

        // score carry and saturation
        g.hit = 1'b1;
        cycles(10);
        g.hit = 1'b0;
        check("carry_score", 32'(g.score), 32'h10);
        g.hit = 1'b1;
        cycles(89);
        g.hit = 1'b0;
        check("s99_score", 32'(g.score), 32'h99);
        g.hit = 1'b1;
        cycles(6);
        g.hit = 1'b0;
        check("s105_score", 32'(g.score), 32'h99);
        g.hit = 1'b1;
        step();
        g.hit = 1'b0;
        check("sat_score", 32'(g.score), 32'h99);

        // miss beats coincident pause edge
        g.miss = 1'b1;
        g.pause_btn = 1'b1;
        step();
        g.miss = 1'b0;
        g.pause_btn = 1'b0;
        check("prio_state", 32'(g.state), 32'd2);
        check("prio_balls", 32'(g.balls), 32'd1);
        g.frame_tick = 1'b1;
        cycles(30);
        g.frame_tick = 1'b0;
        check("mid_state", 32'(g.state), 32'd2);

        // async reset mid-countdown, sampled before any clock edge
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("arst");
        step();
        reset = 1'b0;
        step();
        check("post_rst", 32'(g.state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
